// File: rtl/cronometro_ctrl.sv
// Stopwatch control unit: button conditioning, RESET/COUNT/PAUSE/STOP sequencing, count tick prescaler.
// Optional CRONO_WRAP_EN: overflow clears the counter and keeps counting instead of stopping.

module cronometro_deb #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          s1, s2, acc;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            acc   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == acc) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // accepted level flips; only released->pressed produces an event
                acc   <= s2;
                cnt   <= '0;
                press <= acc;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module cronometro_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int TICK_DIV   = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1_n,
    input  logic       btn2_n,
    input  logic       btn3_n,
    input  logic       btn4_n,
    input  logic       at_max,
    output logic       tick_en,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
`ifdef CRONO_WRAP_EN
    ,
    output logic       wrap
`endif
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {S_RESET = 2'd0, S_COUNT = 2'd1, S_PAUSE = 2'd2, S_STOP = 2'd3} state_t;

    logic [3:0]    btn_n, ev, win;
    state_t        st, st_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick_n, clr_n, run, due;
`ifdef CRONO_WRAP_EN
    logic          wrap_n;
`endif

    assign btn_n = {btn4_n, btn3_n, btn2_n, btn1_n};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        cronometro_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_n (btn_n[i]),
            .press (ev[i])
        );
    end

    always_comb begin
        st_n    = st;
        presc_n = presc;
        tick_n  = 1'b0;
        clr_n   = 1'b0;
`ifdef CRONO_WRAP_EN
        wrap_n  = 1'b0;
`endif
        win = 4'b0000;
        if      (ev[3]) win[3] = 1'b1;
        else if (ev[2]) win[2] = 1'b1;
        else if (ev[1]) win[1] = 1'b1;
        else if (ev[0]) win[0] = 1'b1;

        run = (st == S_COUNT) || (st == S_PAUSE);
        due = run && (presc == PW'(TICK_DIV - 1));
        if (run) presc_n = due ? '0 : presc + 1'b1;

        if (due) begin
            if (!at_max) begin
                tick_n = 1'b1;
            end else begin
`ifdef CRONO_WRAP_EN
                clr_n  = 1'b1;
                wrap_n = 1'b1;
`else
                st_n   = S_STOP;
`endif
            end
        end

        // a due tick is already scheduled above; the button transition lands on the same edge
        case (st)
            S_RESET: if (win[0]) begin st_n = S_COUNT; presc_n = '0; end
            S_COUNT: begin
                if      (win[3]) st_n = S_RESET;
                else if (win[2]) st_n = S_STOP;
                else if (win[1]) st_n = S_PAUSE;
            end
            S_PAUSE: begin
                if      (win[3]) st_n = S_RESET;
                else if (win[2]) st_n = S_STOP;
                else if (win[0]) st_n = S_COUNT;
            end
            S_STOP: begin
                if      (win[3]) st_n = S_RESET;
                else if (win[0]) st_n = S_COUNT;
            end
            default: st_n = S_RESET;
        endcase

        if (st_n == S_RESET && st != S_RESET) begin
            clr_n   = 1'b1;
            presc_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_RESET;
            presc   <= '0;
            tick_en <= 1'b0;
            clr     <= 1'b1;
            hold    <= 1'b0;
`ifdef CRONO_WRAP_EN
            wrap    <= 1'b0;
`endif
        end else begin
            st      <= st_n;
            presc   <= presc_n;
            tick_en <= tick_n;
            clr     <= clr_n;
            hold    <= (st_n == S_PAUSE);
`ifdef CRONO_WRAP_EN
            wrap    <= wrap_n;
`endif
        end
    end

    assign state = st;
endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with DEB_CYCLES=4, TICK_DIV=5.
module tb_cronometro_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'hf;
    logic       at_max = 1'b0;
    logic       tick_en, clr, hold;
    logic [1:0] state;
`ifdef CRONO_WRAP_EN
    logic       wrap;
`endif

    int n_chk = 0, n_fail = 0;
    int cyc = 0, tick_cnt = 0, last_tick = 0;
    int hit_cyc, first_tick, p_hit;
    logic hit_clr, clr_next, hit_hold;

    cronometro_ctrl #(.DEB_CYCLES(4), .TICK_DIV(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn1_n(btn[0]), .btn2_n(btn[1]), .btn3_n(btn[2]), .btn4_n(btn[3]),
        .at_max(at_max), .tick_en(tick_en), .clr(clr), .hold(hold), .state(state)
`ifdef CRONO_WRAP_EN
        , .wrap(wrap)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tick_en === 1'b1) begin tick_cnt++; last_tick = cyc; end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Hold buttons in mask low 10 cycles, then release and let the release debounce.
    task automatic press(input logic [3:0] mask, input logic [1:0] exp, input string name);
        bit found;
        found = 0; hit_cyc = -1; first_tick = -1; p_hit = -1;
        hit_clr = 0; clr_next = 0; hit_hold = 0;
        btn = ~mask;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (found && first_tick < 0 && tick_en === 1'b1) first_tick = cyc - hit_cyc;
            if (found && cyc == hit_cyc + 1) clr_next = clr;
            if (!found && k <= 8 && state === exp) begin
                found = 1; hit_cyc = cyc; hit_clr = clr; hit_hold = hold;
                p_hit = (tick_en === 1'b1) ? 0 : (cyc - last_tick) % 5;
            end
            if (k == 10) btn = 4'hf;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: state=%0d, expected %0d within 8 edges", name, state, exp);
        end
    endtask

    task automatic check_period(input string name);
        int t0, t1;
        t0 = -1; t1 = -1;
        for (int k = 0; k < 12 && t1 < 0; k++) begin
            @(posedge clk); #1;
            if (tick_en === 1'b1) begin
                if (t0 < 0) t0 = cyc; else t1 = cyc;
            end
        end
        n_chk++;
        if (t0 < 0 || t1 < 0 || (t1 - t0) != 5) begin
            n_fail++;
            $display("FAIL %s: tick spacing t0=%0d t1=%0d, expected 5 cycles", name, t0, t1);
        end
    endtask

    task automatic test_reset();
        int t0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: %0d expected 0", state); end
        n_chk++; if (clr !== 1'b1) begin n_fail++; $display("FAIL rst_clr: %b expected 1", clr); end
        n_chk++; if (tick_en !== 1'b0) begin n_fail++; $display("FAIL rst_tick: %b expected 0", tick_en); end
        n_chk++; if (hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold: %b expected 0", hold); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (clr !== 1'b0) begin n_fail++; $display("FAIL rst_clr_drop: %b expected 0", clr); end
        t0 = tick_cnt;
        repeat (50) @(posedge clk); #1;
        n_chk++; if (tick_cnt != t0) begin n_fail++; $display("FAIL rst_no_tick: %0d ticks expected 0", tick_cnt - t0); end
        btn[2] = 1'b0;
        repeat (10) @(posedge clk); #1;
        btn = 4'hf;
        repeat (10) @(posedge clk); #1;
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_ignore_btn3: state=%0d expected 0", state); end
    endtask

    task automatic test_count_glitch();
        press(4'b0001, 2'd1, "count_start");
        check_period("count_period");
        btn[2] = 1'b0;
        repeat (2) @(posedge clk); #1;
        btn = 4'hf;
        repeat (12) @(posedge clk); #1;
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL glitch: state=%0d expected 1", state); end
    endtask

    task automatic test_pause();
        press(4'b0010, 2'd2, "pause_enter");
        n_chk++; if (hit_hold !== 1'b1) begin n_fail++; $display("FAIL pause_hold_edge: %b expected 1", hit_hold); end
        check_period("pause_period");
        n_chk++; if (hold !== 1'b1) begin n_fail++; $display("FAIL pause_hold: %b expected 1", hold); end
        press(4'b0001, 2'd1, "pause_resume");
        n_chk++; if (hold !== 1'b0) begin n_fail++; $display("FAIL resume_hold: %b expected 0", hold); end
    endtask

    task automatic test_stop_resume();
        int p, t0;
        press(4'b0100, 2'd3, "stop_enter");
        p = p_hit;
        t0 = tick_cnt;
        repeat (15) @(posedge clk); #1;
        n_chk++; if (tick_cnt != t0) begin n_fail++; $display("FAIL stop_no_tick: %0d ticks expected 0", tick_cnt - t0); end
        n_chk++; if (state !== 2'd3) begin n_fail++; $display("FAIL stop_state: %0d expected 3", state); end
        press(4'b0001, 2'd1, "stop_resume");
        n_chk++; if (first_tick != 5 - p) begin n_fail++; $display("FAIL resume_residual: first tick after %0d, expected %0d", first_tick, 5 - p); end
        press(4'b1000, 2'd0, "count_reset");
        n_chk++; if (hit_clr !== 1'b1) begin n_fail++; $display("FAIL reset_clr: %b expected 1", hit_clr); end
        n_chk++; if (clr_next !== 1'b0) begin n_fail++; $display("FAIL reset_clr_width: %b expected 0", clr_next); end
    endtask

    task automatic test_simultaneous();
        press(4'b0001, 2'd1, "simul_start");
        press(4'b1111, 2'd0, "simul_all");
        n_chk++; if (hit_clr !== 1'b1) begin n_fail++; $display("FAIL simul_clr: %b expected 1", hit_clr); end
        n_chk++; if (clr_next !== 1'b0) begin n_fail++; $display("FAIL simul_clr_width: %b expected 0", clr_next); end
    endtask

    task automatic test_overflow();
        int ticks;
        bit seen;
        press(4'b0001, 2'd1, "ovf_start");
        at_max = 1'b1; ticks = 0; seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (tick_en === 1'b1) ticks++;
`ifdef CRONO_WRAP_EN
            if (clr === 1'b1 && wrap === 1'b1) seen = 1;
`else
            if (state === 2'd3) seen = 1;
`endif
        end
        at_max = 1'b0;
        n_chk++; if (!seen) begin n_fail++; $display("FAIL ovf_event: state=%0d not seen", state); end
        n_chk++; if (ticks != 0) begin n_fail++; $display("FAIL ovf_tick: %0d ticks expected 0", ticks); end
`ifdef CRONO_WRAP_EN
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL ovf_wrap_state: %0d expected 1", state); end
`else
        n_chk++; if (state !== 2'd3) begin n_fail++; $display("FAIL ovf_state: %0d expected 3", state); end
`endif
    endtask

    task automatic test_async_reset();
        press(4'b0001, 2'd1, "async_start");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL async_state: %0d expected 0", state); end
        n_chk++; if (clr !== 1'b1) begin n_fail++; $display("FAIL async_clr: %b expected 1", clr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count_glitch();
        test_pause();
        test_stop_resume();
        test_simultaneous();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
